// File: rtl/serial_pkg.sv
// Shared types and constants for the serial operand shifter: FSM state
// encoding, default operand width and bit-counter width helper.
package serial_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned SERIAL_WIDTH_DEFAULT = 32'd8;

    // Counter must reach WIDTH when the pad cycle is built in.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 32'd1);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out register: loads a word, shifts right, and
// presents bit 0 as the serial output.
module piso_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-word selection: load has priority over shift.
    always_comb begin
        if (load) begin
            data_d = par_in;
        end else if (shift) begin
            data_d = data_q >> 1'b1;
        end else begin
            data_d = data_q;
        end
    end

    // Word storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign ser_out = data_q[0];

endmodule

// File: rtl/serial_operand_shifter.sv
// Serialises operand pairs A/B LSB-first for a downstream serial adder.
// Optional macro SERIAL_PAD_EN appends one zero pad cycle per word.
module serial_operand_shifter
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             x,
    output logic             y,
    output logic             bit_valid,
    output logic             first,
    output logic             last
);

    localparam int unsigned CW = cnt_width(WIDTH);

`ifdef SERIAL_PAD_EN
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 32'd1);
`endif

    state_e          state_q;
    state_e          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            shifting_s;
    logic            last_s;
    logic            accept_s;
    logic            data_en_s;
    logic            a_bit_s;
    logic            b_bit_s;

    // Handshake and per-bit status decoded from the state and counter flops.
    always_comb begin
        shifting_s = (state_q == SHIFT);
        last_s     = shifting_s && (cnt_q == LAST_CNT);
        in_ready   = !shifting_s || last_s;
        accept_s   = in_valid && in_ready;
`ifdef SERIAL_PAD_EN
        data_en_s  = (cnt_q != CW'(WIDTH));
`else
        data_en_s  = 1'b1;
`endif
        bit_valid  = shifting_s;
        first      = shifting_s && (cnt_q == '0);
        last       = last_s;
        x          = shifting_s && data_en_s && a_bit_s;
        y          = shifting_s && data_en_s && b_bit_s;
    end

    // FSM and bit counter; acceptance on the last bit chains words with no bubble.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept_s) begin
            state_d = SHIFT;
            cnt_d   = '0;
        end else if (shifting_s) begin
            if (last_s) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = SHIFT;
                cnt_d   = cnt_q + CW'(1);
            end
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    piso_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
        .clk     (clk),
        .rst_n   (rst),
        .load    (accept_s),
        .shift   (shifting_s && !accept_s),
        .par_in  (a),
        .ser_out (a_bit_s)
    );

    piso_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
        .clk     (clk),
        .rst_n   (rst),
        .load    (accept_s),
        .shift   (shifting_s && !accept_s),
        .par_in  (b),
        .ser_out (b_bit_s)
    );

endmodule

// File: tb/tb_serial_operand_shifter.sv
// Self-checking bench for serial_operand_shifter (WIDTH=4 and WIDTH=1),
// with a queue-based reference model and a chained serial adder.
module tb_serial_operand_shifter;

    localparam int W = 4;
`ifdef SERIAL_PAD_EN
    localparam int WL = W + 1;
    localparam bit PAD = 1'b1;
`else
    localparam int WL = W;
    localparam bit PAD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, x, y, bit_valid, first, last;

    logic         in_valid1 = 1'b0;
    logic [0:0]   a1 = 1'b0;
    logic [0:0]   b1 = 1'b0;
    logic         in_ready1, x1, y1, bit_valid1, first1, last1;

    serial_operand_shifter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .x(x), .y(y), .bit_valid(bit_valid),
        .first(first), .last(last)
    );

    serial_operand_shifter #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .x(x1), .y(y1), .bit_valid(bit_valid1),
        .first(first1), .last(last1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic x;
        logic y;
        logic first;
        logic last;
    } bit_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] xs;
        logic [W-1:0] ys;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    bit_t mq[$];
    int   sums[$];
    logic carry = 1'b0;
    logic [WL-1:0] zacc = '0;
    int   zidx = 0;

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a word is the list of bits it will show, one per cycle.
    task automatic push_word(input logic [W-1:0] wa, input logic [W-1:0] wb);
        bit_t e;
        logic [WL:0] xa;
        logic [WL:0] yb;
        xa = (WL+1)'(wa);
        yb = (WL+1)'(wb);
        for (int k = 0; k < WL; k++) begin
            e.x     = xa[k];
            e.y     = yb[k];
            e.first = (k == 0);
            e.last  = (k == WL - 1);
            mq.push_back(e);
        end
        sums.push_back((int'(wa) + int'(wb)) & ((1 << WL) - 1));
    endtask

    task automatic adder_step();
        logic cin;
        logic zb;
        if (bit_valid) begin
            cin   = first ? 1'b0 : carry;
            zb    = x ^ y ^ cin;
            carry = (x & y) | (x & cin) | (y & cin);
            if (zidx < WL) zacc[zidx] = zb;
            zidx++;
            if (last) begin
                if (sums.size() == 0) begin
                    check("adder_word", {2'b00, zacc}, 6'b111111);
                end else begin
                    check("adder_sum", 6'(zacc), 6'(sums.pop_front()));
                end
                zidx = 0;
                zacc = '0;
            end
        end
    endtask

    task automatic cycle();
        logic acc;
        logic [5:0] exp;
        acc = in_valid && (mq.size() <= 1);
        @(posedge clk);
        if (mq.size() > 0) void'(mq.pop_front());
        if (acc) push_word(a, b);
        #1;
        if (mq.size() > 0)
            exp = {mq[0].x, mq[0].y, 1'b1, mq[0].first, mq[0].last, mq.size() <= 1};
        else
            exp = 6'b000001;
        check("cycle", {x, y, bit_valid, first, last, in_ready}, exp);
        adder_step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mq.delete();
        sums.delete();
        zidx = 0;
        zacc = '0;
        #1;
        check("reset_outputs", {x, y, bit_valid, first, last, in_ready}, 6'b000001);
    endtask

    vec_t tbl[5];
    logic [15:0] bvm;
    logic [15:0] fm;

    initial begin
        tbl[0] = '{4'b1011, 4'b0110, 4'b1011, 4'b0110};
        tbl[1] = '{4'h3, 4'h5, 4'b0011, 4'b0101};
        tbl[2] = '{4'hF, 4'h1, 4'b1111, 4'b0001};
        tbl[3] = '{4'h0, 4'h0, 4'b0000, 4'b0000};
        tbl[4] = '{4'hA, 4'h5, 4'b1010, 4'b0101};

        do_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle();
        cycle();

        // Single-word table vectors.
        for (int t = 0; t < 5; t++) begin
            in_valid = 1'b1;
            a = tbl[t].a;
            b = tbl[t].b;
            cycle();
            in_valid = 1'b0;
            a = ~tbl[t].a;
            for (int k = 0; k < WL; k++) begin
                check("tbl_bit", {2'b00, x, y, first, last},
                      {2'b00, (k < W) ? tbl[t].xs[k % W] : 1'b0,
                       (k < W) ? tbl[t].ys[k % W] : 1'b0, k == 0, k == WL - 1});
                cycle();
            end
            check("tbl_idle", {4'b0000, bit_valid, in_ready}, 6'b000001);
        end

        // Back-to-back words with the next pair held valid.
        in_valid = 1'b1; a = 4'h3; b = 4'h5;
        cycle();
        a = 4'hF; b = 4'h1;
        bvm = '0; fm = '0;
        for (int k = 0; k < 2 * WL; k++) begin
            bvm[k] = bit_valid;
            fm[k]  = first;
            cycle();
            if (k == WL - 1) in_valid = 1'b0;
        end
        check("b2b_valid", 6'(bvm >> 8), 6'(((32'd1 << (2 * WL)) - 32'd1) >> 8));
        check("b2b_valid_lo", 6'(bvm), 6'((32'd1 << (2 * WL)) - 32'd1));
        check("b2b_first", 6'(fm), 6'((32'd1) | (32'd1 << WL)));

        // Operand offered mid-word must wait for in_ready.
        in_valid = 1'b1; a = 4'h6; b = 4'h2;
        cycle();
        in_valid = 1'b0;
        cycle();
        in_valid = 1'b1; a = 4'h9; b = 4'h9;
        for (int k = 0; k < 2 * WL; k++) begin
            if (in_valid && in_ready) begin
                cycle();
                in_valid = 1'b0;
            end else begin
                cycle();
            end
        end
        check("late_accepted", {5'b00000, in_valid}, 6'b000000);
        for (int k = 0; k < WL + 1; k++) cycle();

        // Asynchronous reset during bit 2.
        in_valid = 1'b1; a = 4'hB; b = 4'h7;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        #2;
        do_reset();
        @(negedge clk);
        check("reset_hold", {x, y, bit_valid, first, last, in_ready}, 6'b000001);
        rst = 1'b1;
        in_valid = 1'b1; a = 4'h5; b = 4'hC;
        cycle();
        in_valid = 1'b0;
        check("post_reset_first", {4'b0000, bit_valid, first}, 6'b000011);
        for (int k = 0; k < WL; k++) cycle();

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a = W'($urandom);
            b = W'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        for (int k = 0; k < WL + 2; k++) cycle();

        // WIDTH=1 instance: one bit carrying both first and last.
        @(negedge clk);
        in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        check("w1_bit0", {x1, y1, bit_valid1, first1, last1, in_ready1},
              {4'b1111, !PAD, !PAD});
`ifdef SERIAL_PAD_EN
        @(posedge clk); #1;
        check("w1_pad", {x1, y1, bit_valid1, first1, last1, in_ready1}, 6'b001011);
`endif
        @(posedge clk); #1;
        check("w1_idle", {x1, y1, bit_valid1, first1, last1, in_ready1}, 6'b000001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
